// File: rtl/predict.sv
// Predict stage of a lifting wavelet: pairs even/odd samples, emits the detail
// coefficient (odd - even) followed by the even sample for the update stage.
module predict #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] sample_in,
    input  logic              sample_valid,
    input  logic              sample_last,
    output logic              sample_ready,
    output logic [DATA_W-1:0] detail_cofficient,
    output logic              detail_valid,
    output logic [DATA_W-1:0] even_input,
    output logic              even_valid,
    output logic              frame_done,
    output logic [7:0]        pair_count
);

    typedef enum logic [1:0] {
        IDLE_EVEN,
        WAIT_ODD,
        EMIT_DETAIL,
        EMIT_EVEN
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [DATA_W-1:0] even_reg;
    logic              last_flag;
    logic              transfer;

    assign transfer = sample_valid & sample_ready;

    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values, independent of the order the blocks are evaluated.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE_EVEN;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every signal driven here gets a default first; a missing branch
    // would otherwise infer a latch.
    always_comb begin
        state_next   = state;
        sample_ready = 1'b0;
        detail_valid = 1'b0;
        even_valid   = 1'b0;
        frame_done   = 1'b0;
        case (state)
            IDLE_EVEN: begin
                sample_ready = 1'b1;
                if (transfer) begin
                    state_next = sample_last ? EMIT_DETAIL : WAIT_ODD;
                end
            end
            WAIT_ODD: begin
                sample_ready = 1'b1;
                if (transfer) begin
                    state_next = EMIT_DETAIL;
                end
            end
            EMIT_DETAIL: begin
                detail_valid = 1'b1;
                state_next   = EMIT_EVEN;
            end
            EMIT_EVEN: begin
                even_valid = 1'b1;
                frame_done = last_flag;
                state_next = IDLE_EVEN;
            end
            default: state_next = IDLE_EVEN;
        endcase
    end

    // A lone final even sample pads its odd partner with itself, so detail is 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            even_reg          <= '0;
            last_flag         <= 1'b0;
            detail_cofficient <= '0;
            even_input        <= '0;
            pair_count        <= '0;
        end else begin
            case (state)
                IDLE_EVEN: begin
                    if (transfer) begin
                        even_reg <= sample_in;
                        if (sample_last) begin
                            detail_cofficient <= '0;
                            last_flag         <= 1'b1;
                        end
                    end
                end
                WAIT_ODD: begin
                    if (transfer) begin
                        detail_cofficient <= sample_in - even_reg;
                        last_flag         <= sample_last;
                    end
                end
                EMIT_DETAIL: begin
                    pair_count <= pair_count + 8'd1;
                    even_input <= even_reg;
                end
                EMIT_EVEN: begin
                    last_flag <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_predict.sv
// Self-checking bench for predict: randomized pairs against an arithmetic
// model of the expected detail/even/pair_count stream, plus directed corners.
module tb_predict;

    logic       clk;
    logic       rst;
    logic [7:0] sample_in;
    logic       sample_valid;
    logic       sample_last;
    logic       sample_ready;
    logic [7:0] detail_cofficient;
    logic       detail_valid;
    logic [7:0] even_input;
    logic       even_valid;
    logic       frame_done;
    logic [7:0] pair_count;

    int tests_run;
    int tests_failed;

    // Reference model: last emitted values and pairs emitted since reset.
    logic [7:0] exp_detail;
    logic [7:0] exp_even;
    int         exp_pairs;

    predict #(.DATA_W(8)) dut (
        .clk              (clk),
        .rst              (rst),
        .sample_in        (sample_in),
        .sample_valid     (sample_valid),
        .sample_last      (sample_last),
        .sample_ready     (sample_ready),
        .detail_cofficient(detail_cofficient),
        .detail_valid     (detail_valid),
        .even_input       (even_input),
        .even_valid       (even_valid),
        .frame_done       (frame_done),
        .pair_count       (pair_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic drive_junk();
        sample_valid = 1'($urandom);
        sample_in    = 8'($urandom);
        sample_last  = 1'($urandom);
    endtask

    task automatic drive_idle();
        sample_valid = 1'b0;
        sample_in    = 8'($urandom);
        sample_last  = 1'($urandom);
    endtask

    // One pair: even transfer, optional stall, odd transfer (skipped when the
    // even sample is last), then the detail and even emission cycles.
    task automatic send_pair(input logic [7:0] e, input logic [7:0] o,
                             input bit le, input bit lo, input int stall);
        logic [7:0] d;
        d = le ? 8'd0 : 8'(o - e);

        @(negedge clk);
        check("idle_ready", sample_ready, 1);
        check("idle_detail_hold", detail_cofficient, exp_detail);
        check("idle_even_hold", even_input, exp_even);
        sample_valid = 1'b1;
        sample_in    = e;
        sample_last  = le;

        if (!le) begin
            for (int i = 0; i < stall; i++) begin
                @(negedge clk);
                check("wait_ready", sample_ready, 1);
                check("wait_no_valid", {detail_valid, even_valid}, 0);
                drive_idle();
            end
            @(negedge clk);
            check("odd_ready", sample_ready, 1);
            sample_valid = 1'b1;
            sample_in    = o;
            sample_last  = lo;
        end

        @(negedge clk);
        exp_detail = d;
        check("detail_valid", detail_valid, 1);
        check("detail_excl", even_valid, 0);
        check("detail_ready", sample_ready, 0);
        check("detail_value", detail_cofficient, exp_detail);
        check("detail_fd", frame_done, 0);
        drive_junk();

        @(negedge clk);
        exp_pairs++;
        exp_even = e;
        check("even_valid", even_valid, 1);
        check("even_excl", detail_valid, 0);
        check("even_ready", sample_ready, 0);
        check("even_value", even_input, exp_even);
        check("even_detail_hold", detail_cofficient, exp_detail);
        check("frame_done", frame_done, 32'(le | lo));
        check("pair_count", pair_count, 32'(exp_pairs % 256));
        drive_junk();

        @(negedge clk);
        check("post_no_valid", {detail_valid, even_valid, frame_done}, 0);
        drive_idle();
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        exp_detail   = 8'd0;
        exp_even     = 8'd0;
        exp_pairs    = 0;
        rst          = 1'b1;
        drive_idle();
        repeat (2) @(negedge clk);
        check("rst_ready", sample_ready, 1);
        check("rst_outputs", {detail_cofficient, even_input, pair_count}, 0);
        check("rst_flags", {detail_valid, even_valid, frame_done}, 0);
        rst = 1'b0;

        send_pair(8'd6, 8'd46, 1'b0, 1'b0, 0);
        send_pair(8'd200, 8'd10, 1'b0, 1'b0, 0);
        send_pair(8'd9, 8'd0, 1'b1, 1'b0, 0);
        send_pair(8'd0, 8'd255, 1'b0, 1'b1, 2);

        for (int n = 0; n < 40; n++) begin
            send_pair(8'($urandom), 8'($urandom), ($urandom_range(0, 7) == 0),
                      ($urandom_range(0, 3) == 0), int'($urandom_range(0, 2)));
            repeat ($urandom_range(0, 2)) begin
                @(negedge clk);
                check("gap_ready", sample_ready, 1);
                drive_idle();
            end
        end

        // Asynchronous reset while the detail coefficient is being emitted.
        @(negedge clk);
        sample_valid = 1'b1;
        sample_in    = 8'd17;
        sample_last  = 1'b0;
        @(negedge clk);
        sample_in    = 8'd99;
        @(negedge clk);
        check("pre_rst_detail", detail_valid, 1);
        drive_idle();
        #2 rst = 1'b1;
        #1;
        exp_pairs  = 0;
        exp_detail = 8'd0;
        exp_even   = 8'd0;
        check("arst_flags", {detail_valid, even_valid, frame_done}, 0);
        check("arst_values", {detail_cofficient, even_input, pair_count}, 0);
        check("arst_ready", sample_ready, 1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_no_even", {even_valid, detail_valid}, 0);
        check("post_rst_ready", sample_ready, 1);
        check("post_rst_count", pair_count, 32'(exp_pairs));

        for (int n = 0; n < 256; n++) begin
            send_pair(8'($urandom), 8'($urandom), 1'b0, 1'b0, 0);
        end
        check("wrap_count", pair_count, 32'(exp_pairs % 256));

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
